fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named exactly as listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 pc_in  input  32  next fetch address from PC stage.
REQ-005 pc_active  input  1  PC stage running; no fetch is issued while low.
REQ-006 flush  input  1  jump/branch taken; squashes in-flight fetch and IF/ID contents.
REQ-007 decode_stall  input  1  decode cannot accept a new instruction this cycle.
REQ-008 imem_address  output  32  word-aligned instruction memory byte address.
REQ-009 imem_read  output  1  read request, Avalon-style.
REQ-010 imem_waitrequest  input  1  memory not ready; request must be held.
REQ-011 imem_readdata  input  32  instruction word, valid when imem_read=1 and imem_waitrequest=0.
REQ-012 instr_out  output  32  IF/ID instruction register.
REQ-013 instr_pc_out  output  32  address of instr_out.
REQ-014 instr_valid  output  1  instr_out holds a live instruction.
REQ-015 pc_stall  output  1  drives PC stage PC_Stall; holds PC.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, REQ, HOLD.
- IDLE->REQ when pc_active=1; req_addr<=pc_in.
- REQ: imem_read=1, imem_address={req_addr[31:2],2'b00}.
- HOLD: imem_read=0.
REQ-017 A fetch completes on a REQ cycle with imem_waitrequest=0; completion with decode_stall=0 and no squash SHALL load instr_out<=imem_readdata, instr_pc_out<=req_addr, instr_valid<=1, req_addr<=pc_in, and leave the state in REQ.
REQ-018 A completion with decode_stall=1 SHALL store the word and address in the hold buffer and go to HOLD; HOLD->REQ on the first cycle decode_stall=0, loading IF/ID from the buffer and req_addr<=pc_in.
REQ-019 While decode_stall=1, instr_out, instr_pc_out and instr_valid SHALL hold their values.
REQ-020 While decode_stall=0 and no completion occurs, instr_valid SHALL be 0 on the next edge (bubble).
REQ-021 pc_stall SHALL be combinational: 1 unless pc_active=1, state=REQ, imem_waitrequest=0 and decode_stall=0, or state=IDLE with pc_active=1.
REQ-022 imem_address and imem_read SHALL stay constant while imem_waitrequest=1, including across flush.
REQ-023 Flush, REQ and imem_waitrequest=1: set squash flag; the pending completion SHALL be discarded, then req_addr<=pc_in.
REQ-024 Flush, REQ and imem_waitrequest=0: the returned word SHALL be discarded and req_addr<=pc_in in the same edge.
REQ-025 Flush in HOLD SHALL empty the hold buffer and go to REQ with req_addr<=pc_in.
REQ-026 Any flush SHALL clear instr_valid next edge; flush overrides decode_stall.
REQ-027 pc_active falling in REQ SHALL still finish the outstanding read (discarded), then go to IDLE.
REQ-028 Fetch latency SHALL be 1 cycle from request to instr_valid with imem_waitrequest=0; throughput SHALL be 1 instruction per cycle.

Reset
REQ-029 While rst=1: state=IDLE, imem_read=0, imem_address=0, instr_out=0, instr_pc_out=0, instr_valid=0, squash=0, hold buffer empty, req_addr=0.
REQ-030 Reset asserted mid-read SHALL drop imem_read immediately; no result is delivered.

Structure
REQ-031 Package fetch_pkg SHALL hold the state enum, the NOP constant 32'h0000_0000 and the reset vector 32'hBFC0_0000.
REQ-032 The hold buffer SHALL be sub-module fetch_hold_buf: 1-entry, 64-bit storage, load/unload/clear controls.

Verification
REQ-033 Reset then pc_active=1, pc_in=BFC00000, waitrequest=0 -> imem_read next cycle, address BFC00000; instr_valid=1 and instr_pc_out=BFC00000 one cycle later.
REQ-034 waitrequest held 3 cycles -> imem_address stable, pc_stall=1 for 3 cycles; 4th cycle delivers the word.
REQ-035 decode_stall=1 at completion with readdata=8C010004 -> HOLD, imem_read=0; on release instr_out=8C010004.
REQ-036 flush during waitrequest=1 -> read held until accept, word discarded, instr_valid=0; next fetch uses new pc_in=BFC00100.
REQ-037 rst pulsed while in REQ -> all outputs zero immediately; restart fetches BFC00000 cleanly.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM states (IDLE, REQ, HOLD)
//   NOP           : value of the IF/ID instruction register after reset
//   RESET_VEC     : architectural reset vector of the PC stage
//   word_align()  : forces a byte address onto a 32-bit word boundary
// ---------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP       = 32'h0000_0000;
   localparam logic [31:0] RESET_VEC = 32'hBFC0_0000;

   function automatic logic [31:0] word_align(input logic [31:0] i_addr);
      return {i_addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// ---------------------------------------------------------------------------
// fetch_hold_buf
// One-entry, 64-bit holding register for a fetched {pc, instruction} pair
// that arrived while decode was stalled.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset (empties the buffer)
//   i_load   : capture i_data, buffer becomes full
//   i_unload : buffer contents consumed, buffer becomes empty
//   i_clear  : discard contents (flush); wins over load/unload
//   i_data   : {pc[31:0], instr[31:0]}
//   o_data   : stored {pc, instr}
//   o_full   : buffer holds a live entry
// ---------------------------------------------------------------------------
module fetch_hold_buf
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic        i_unload,
   input  logic        i_clear,
   input  logic [63:0] i_data,
   output logic [63:0] o_data,
   output logic        o_full
);

   logic        r_full;
   logic [63:0] r_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full <= 1'b0;
      end else if (i_clear) begin
         r_full <= 1'b0;
      end else if (i_load) begin
         r_full <= 1'b1;
      end else if (i_unload) begin
         r_full <= 1'b0;
      end
   end

   // Payload is only meaningful while r_full is set, so it carries no reset.
   always_ff @(posedge clk) begin
      if (i_load) begin
         r_data <= i_data;
      end
   end

   assign o_data = r_data;
   assign o_full = r_full;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: issues Avalon-style reads to instruction memory and
// fills the IF/ID register, with a one-entry hold buffer for words that
// return while decode is stalled.
//   clk, rst          : clock, asynchronous active-high reset
//   pc_in             : next fetch address from the PC stage
//   pc_active         : PC stage running; no new fetch while low
//   flush             : taken jump/branch; squashes in-flight fetch and IF/ID
//   decode_stall      : decode cannot accept an instruction this cycle
//   imem_address      : word-aligned read address
//   imem_read         : read request
//   imem_waitrequest  : memory not ready; request is held
//   imem_readdata     : returned instruction word
//   instr_out         : IF/ID instruction
//   instr_pc_out      : address of instr_out
//   instr_valid       : instr_out is live
//   pc_stall          : holds the PC stage
// ---------------------------------------------------------------------------
module fetch_stage
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   input  logic        pc_active,
   input  logic        flush,
   input  logic        decode_stall,
   output logic [31:0] imem_address,
   output logic        imem_read,
   input  logic        imem_waitrequest,
   input  logic [31:0] imem_readdata,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc_out,
   output logic        instr_valid,
   output logic        pc_stall
);

   fetch_state_t r_state;
   fetch_state_t w_next_state;
   logic         w_load_addr;

   logic [31:0]  r_req_addr;
   logic         r_squash;
   logic [31:0]  r_instr;
   logic [31:0]  r_instr_pc;
   logic         r_instr_valid;

   logic         w_done;
   logic         w_discard;
   logic         w_accept;
   logic         w_to_buf;
   logic         w_deliver_rd;
   logic         w_release;
   logic         w_buf_clear;
   logic [63:0]  w_buf_data;
   logic         w_buf_full;

   // A read completes on any REQ cycle the memory accepts it. The word is
   // thrown away if a flush is pending (squash) or arrives now, or if the PC
   // stage has stopped.
   assign w_done       = (r_state == REQ) && !imem_waitrequest;
   assign w_discard    = r_squash || flush || !pc_active;
   assign w_accept     = w_done && !w_discard;
   assign w_to_buf     = w_accept && decode_stall;
   assign w_deliver_rd = w_accept && !decode_stall;
   assign w_release    = (r_state == HOLD) && w_buf_full && !flush && !decode_stall;
   assign w_buf_clear  = (r_state == HOLD) && flush;

   fetch_hold_buf u_hold_buf (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_to_buf),
      .i_unload (w_release),
      .i_clear  (w_buf_clear),
      .i_data   ({r_req_addr, imem_readdata}),
      .o_data   (w_buf_data),
      .o_full   (w_buf_full)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_load_addr  = 1'b0;
      case (r_state)
         IDLE: begin
            if (pc_active) begin
               w_next_state = REQ;
               w_load_addr  = 1'b1;
            end
         end
         REQ: begin
            // Address stays frozen until the memory accepts the request.
            if (w_done) begin
               if (w_to_buf) begin
                  w_next_state = HOLD;
               end else begin
                  w_load_addr = 1'b1;
                  if (!pc_active) begin
                     w_next_state = IDLE;
                  end
               end
            end
         end
         HOLD: begin
            if (flush || !decode_stall) begin
               w_next_state = REQ;
               w_load_addr  = 1'b1;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req_addr <= 32'h0;
      end else if (w_load_addr) begin
         r_req_addr <= pc_in;
      end
   end

   // A flush seen while the memory is still busy must kill the word that
   // eventually comes back, since the request itself cannot be withdrawn.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_squash <= 1'b0;
      end else if (w_done) begin
         r_squash <= 1'b0;
      end else if ((r_state == REQ) && flush) begin
         r_squash <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr       <= NOP;
         r_instr_pc    <= 32'h0;
         r_instr_valid <= 1'b0;
      end else if (flush) begin
         r_instr_valid <= 1'b0;
      end else if (decode_stall) begin
         r_instr_valid <= r_instr_valid;
      end else if (w_deliver_rd) begin
         r_instr       <= imem_readdata;
         r_instr_pc    <= r_req_addr;
         r_instr_valid <= 1'b1;
      end else if (w_release) begin
         r_instr       <= w_buf_data[31:0];
         r_instr_pc    <= w_buf_data[63:32];
         r_instr_valid <= 1'b1;
      end else begin
         r_instr_valid <= 1'b0;
      end
   end

   assign imem_read    = (r_state == REQ);
   assign imem_address = word_align(r_req_addr);
   assign pc_stall     = !((pc_active && (r_state == REQ) && !imem_waitrequest && !decode_stall) ||
                           ((r_state == IDLE) && pc_active));

   assign instr_out    = r_instr;
   assign instr_pc_out = r_instr_pc;
   assign instr_valid  = r_instr_valid;

endmodule
